// File: rtl/mem_req_scheduler.sv
// Shares one main_mem request port between icache and dcache, tracks one outstanding read per cache.
// Optional: define MEM_SCHED_RR_EN for round-robin tie-breaking instead of dcache priority with starvation override.
module mem_req_scheduler #(
   parameter int ADDR_W       = 29,
   parameter int DATA_W       = 64,
   parameter int STARVE_LIMIT = 3
) (
   input  logic              clk,
   input  logic              rst_aH,
   input  logic              icache_req_valid,
   input  logic [ADDR_W-1:0] icache_req_block_addr,
   output logic              icache_req_ready,
   output logic              icache_resp_valid,
   output logic [DATA_W-1:0] icache_resp_block_data,
   input  logic              dcache_req_valid,
   input  logic              dcache_req_type,
   input  logic [ADDR_W-1:0] dcache_req_block_addr,
   input  logic [DATA_W-1:0] dcache_req_block_data,
   output logic              dcache_req_ready,
   output logic              dcache_resp_valid,
   output logic [DATA_W-1:0] dcache_resp_block_data,
   output logic              mem_req_valid,
   output logic              mem_req_cache_type,
   output logic              mem_req_type,
   output logic [ADDR_W-1:0] mem_req_block_addr,
   output logic [DATA_W-1:0] mem_req_block_data,
   input  logic              mem_resp_valid,
   input  logic              mem_resp_cache_type,
   input  logic [DATA_W-1:0] mem_resp_block_data,
   output logic              protocol_err
);

   logic              ibusy_q, ibusy_d;
   logic              dbusy_q, dbusy_d;
   logic              perr_q, perr_d;
   logic              mreq_valid_q, mreq_valid_d;
   logic              mreq_ctype_q, mreq_ctype_d;
   logic              mreq_type_q, mreq_type_d;
   logic [ADDR_W-1:0] mreq_addr_q, mreq_addr_d;
   logic [DATA_W-1:0] mreq_data_q, mreq_data_d;

   logic elig_i, elig_d;
   logic gnt_i, gnt_d;
   logic fire_i, fire_d;
   logic rsp_i, rsp_d;
   logic tie_to_icache;

`ifdef MEM_SCHED_RR_EN
   // 1 = dcache won the most recent grant, so icache takes the next tie
   logic last_dc_q, last_dc_d;
   assign tie_to_icache = last_dc_q;
`else
   localparam logic [3:0] SLIM = 4'(STARVE_LIMIT);
   logic [3:0] scnt_q, scnt_d;
   assign tie_to_icache = (scnt_q == SLIM);
`endif

   always_comb begin
      elig_i = icache_req_valid && !ibusy_q;
      elig_d = dcache_req_valid && !dbusy_q;
      gnt_i  = elig_i && (!elig_d || tie_to_icache);
      gnt_d  = elig_d && !gnt_i;
   end

   assign icache_req_ready = gnt_i;
   assign dcache_req_ready = gnt_d;
   assign fire_i = icache_req_valid && icache_req_ready;
   assign fire_d = dcache_req_valid && dcache_req_ready;

   assign rsp_i = mem_resp_valid && !mem_resp_cache_type;
   assign rsp_d = mem_resp_valid &&  mem_resp_cache_type;

   assign icache_resp_valid      = rsp_i && ibusy_q;
   assign dcache_resp_valid      = rsp_d && dbusy_q;
   assign icache_resp_block_data = mem_resp_block_data;
   assign dcache_resp_block_data = mem_resp_block_data;

   always_comb begin
      mreq_valid_d = 1'b0;
      mreq_ctype_d = mreq_ctype_q;
      mreq_type_d  = mreq_type_q;
      mreq_addr_d  = mreq_addr_q;
      mreq_data_d  = mreq_data_q;
      if (fire_i) begin
         mreq_valid_d = 1'b1;
         mreq_ctype_d = 1'b0;
         mreq_type_d  = 1'b0;
         mreq_addr_d  = icache_req_block_addr;
         mreq_data_d  = '0;
      end else if (fire_d) begin
         mreq_valid_d = 1'b1;
         mreq_ctype_d = 1'b1;
         mreq_type_d  = dcache_req_type;
         mreq_addr_d  = dcache_req_block_addr;
         mreq_data_d  = dcache_req_block_data;
      end
   end

   // A cache can only fire while idle, so set and clear never collide on one flag
   always_comb begin
      ibusy_d = fire_i || (ibusy_q && !rsp_i);
      dbusy_d = (fire_d && !dcache_req_type) || (dbusy_q && !rsp_d);
      perr_d  = perr_q || (rsp_i && !ibusy_q) || (rsp_d && !dbusy_q);
   end

`ifdef MEM_SCHED_RR_EN
   always_comb begin
      last_dc_d = last_dc_q;
      if (fire_i) begin
         last_dc_d = 1'b0;
      end else if (fire_d) begin
         last_dc_d = 1'b1;
      end
   end
`else
   always_comb begin
      scnt_d = scnt_q;
      if (fire_i) begin
         scnt_d = 4'd0;
      end else if (elig_i && gnt_d && (scnt_q < SLIM)) begin
         scnt_d = scnt_q + 4'd1;
      end
   end
`endif

   always_ff @(posedge clk or posedge rst_aH) begin
      if (rst_aH) begin
         ibusy_q      <= 1'b0;
         dbusy_q      <= 1'b0;
         perr_q       <= 1'b0;
         mreq_valid_q <= 1'b0;
         mreq_ctype_q <= 1'b0;
         mreq_type_q  <= 1'b0;
         mreq_addr_q  <= '0;
         mreq_data_q  <= '0;
`ifdef MEM_SCHED_RR_EN
         last_dc_q    <= 1'b1;
`else
         scnt_q       <= 4'd0;
`endif
      end else begin
         ibusy_q      <= ibusy_d;
         dbusy_q      <= dbusy_d;
         perr_q       <= perr_d;
         mreq_valid_q <= mreq_valid_d;
         mreq_ctype_q <= mreq_ctype_d;
         mreq_type_q  <= mreq_type_d;
         mreq_addr_q  <= mreq_addr_d;
         mreq_data_q  <= mreq_data_d;
`ifdef MEM_SCHED_RR_EN
         last_dc_q    <= last_dc_d;
`else
         scnt_q       <= scnt_d;
`endif
      end
   end

   assign mem_req_valid      = mreq_valid_q;
   assign mem_req_cache_type = mreq_ctype_q;
   assign mem_req_type       = mreq_type_q;
   assign mem_req_block_addr = mreq_addr_q;
   assign mem_req_block_data = mreq_data_q;
   assign protocol_err       = perr_q;

endmodule

// File: tb/tb_mem_req_scheduler.sv
// Testbench for mem_req_scheduler: directed vector tables, a reset/stale-response sequence,
// and randomized traffic checked against a per-cache outstanding/loss-count reference model.
module tb_mem_req_scheduler;
   localparam int AW = 29;
   localparam int DW = 64;
   localparam int SL = 3;

   logic          clk = 1'b0;
   logic          rst_aH = 1'b1;
   logic          iv = 1'b0, dv = 1'b0, dt = 1'b0, rv = 1'b0, rt = 1'b0;
   logic [AW-1:0] ia = '0, da = '0;
   logic [DW-1:0] dd = '0, rd = '0;
   logic          icache_req_ready, icache_resp_valid, dcache_req_ready, dcache_resp_valid;
   logic [DW-1:0] icache_resp_block_data, dcache_resp_block_data;
   logic          mem_req_valid, mem_req_cache_type, mem_req_type, protocol_err;
   logic [AW-1:0] mem_req_block_addr;
   logic [DW-1:0] mem_req_block_data;

   always #5 clk = ~clk;

   mem_req_scheduler #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL)) dut (
      .clk(clk), .rst_aH(rst_aH),
      .icache_req_valid(iv), .icache_req_block_addr(ia), .icache_req_ready(icache_req_ready),
      .icache_resp_valid(icache_resp_valid), .icache_resp_block_data(icache_resp_block_data),
      .dcache_req_valid(dv), .dcache_req_type(dt), .dcache_req_block_addr(da),
      .dcache_req_block_data(dd), .dcache_req_ready(dcache_req_ready),
      .dcache_resp_valid(dcache_resp_valid), .dcache_resp_block_data(dcache_resp_block_data),
      .mem_req_valid(mem_req_valid), .mem_req_cache_type(mem_req_cache_type),
      .mem_req_type(mem_req_type), .mem_req_block_addr(mem_req_block_addr),
      .mem_req_block_data(mem_req_block_data),
      .mem_resp_valid(rv), .mem_resp_cache_type(rt), .mem_resp_block_data(rd),
      .protocol_err(protocol_err)
   );

   typedef struct {
      logic          iv;
      logic [AW-1:0] ia;
      logic          dv, dt;
      logic [AW-1:0] da;
      logic [DW-1:0] dd;
      logic          rv, rt;
      logic [DW-1:0] rd;
      logic          e_ir, e_dr, e_irv, e_drv, e_mv, e_mct, e_mty, e_perr;
      logic [AW-1:0] e_ma;
      logic [DW-1:0] e_md;
   } vec_t;

   int n_vec = 0;
   int n_err = 0;

   // reference model: which caches have a read outstanding, consecutive icache losses,
   // who won last, sticky error, and the request most recently handed to main_mem
   bit            m_busy [2];
   int            m_loss;
   bit            m_last_dc;
   bit            m_perr;
   bit            m_mv, m_mct, m_mty;
   logic [AW-1:0] m_ma;
   logic [DW-1:0] m_md;

   function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endfunction

   function automatic vec_t mk(logic iv_, logic [AW-1:0] ia_, logic dv_, logic dt_,
                               logic [AW-1:0] da_, logic [DW-1:0] dd_, logic rv_, logic rt_,
                               logic [DW-1:0] rd_, logic ir_, logic dr_, logic irv_, logic drv_,
                               logic mv_, logic mct_, logic mty_, logic [AW-1:0] ma_,
                               logic [DW-1:0] md_);
      vec_t v;
      v.iv = iv_; v.ia = ia_; v.dv = dv_; v.dt = dt_; v.da = da_; v.dd = dd_;
      v.rv = rv_; v.rt = rt_; v.rd = rd_;
      v.e_ir = ir_; v.e_dr = dr_; v.e_irv = irv_; v.e_drv = drv_;
      v.e_mv = mv_; v.e_mct = mct_; v.e_mty = mty_; v.e_ma = ma_; v.e_md = md_;
      v.e_perr = 1'b0;
      return v;
   endfunction

   function automatic void model_reset();
      m_busy[0] = 0; m_busy[1] = 0;
      m_loss = 0; m_last_dc = 1; m_perr = 0;
      m_mv = 0; m_mct = 0; m_mty = 0; m_ma = '0; m_md = '0;
   endfunction

   function automatic vec_t model_expect(vec_t v);
      vec_t e = v;
      bit ei = v.iv && !m_busy[0];
      bit ed = v.dv && !m_busy[1];
      bit icache_takes_tie;
`ifdef MEM_SCHED_RR_EN
      icache_takes_tie = m_last_dc;
`else
      icache_takes_tie = (m_loss == SL);
`endif
      e.e_ir   = ei && (!ed || icache_takes_tie);
      e.e_dr   = ed && !e.e_ir;
      e.e_irv  = v.rv && (v.rt == 1'b0) && m_busy[0];
      e.e_drv  = v.rv && (v.rt == 1'b1) && m_busy[1];
      e.e_mv   = m_mv; e.e_mct = m_mct; e.e_mty = m_mty;
      e.e_ma   = m_ma; e.e_md = m_md;
      e.e_perr = m_perr;
      return e;
   endfunction

   function automatic void model_commit(vec_t v, vec_t e);
      bit ei = v.iv && !m_busy[0];
      if (v.rv) begin
         if (m_busy[v.rt]) m_busy[v.rt] = 0;
         else m_perr = 1;
      end
      if (e.e_ir) begin
         m_busy[0] = 1;
         m_mv = 1; m_mct = 0; m_mty = 0; m_ma = v.ia; m_md = '0;
         m_loss = 0; m_last_dc = 0;
      end else if (e.e_dr) begin
         if (!v.dt) m_busy[1] = 1;
         m_mv = 1; m_mct = 1; m_mty = v.dt; m_ma = v.da; m_md = v.dd;
         if (ei && m_loss < SL) m_loss++;
         m_last_dc = 1;
      end else begin
         m_mv = 0;
      end
   endfunction

   task automatic drive_idle();
      iv = 0; ia = '0; dv = 0; dt = 0; da = '0; dd = '0; rv = 0; rt = 0; rd = '0;
   endtask

   task automatic do_reset();
      drive_idle();
      rst_aH = 1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst mem_req_valid", mem_req_valid, 0);
      chk("rst mem_req_cache_type", mem_req_cache_type, 0);
      chk("rst mem_req_type", mem_req_type, 0);
      chk("rst mem_req_block_addr", mem_req_block_addr, 0);
      chk("rst mem_req_block_data", mem_req_block_data, 0);
      chk("rst protocol_err", protocol_err, 0);
      rst_aH = 0;
   endtask

   // called at posedge+1: drive, compare at the falling edge, advance to next posedge+1
   task automatic step(input vec_t v, input bit use_tab);
      vec_t m, e;
      iv = v.iv; ia = v.ia; dv = v.dv; dt = v.dt; da = v.da; dd = v.dd;
      rv = v.rv; rt = v.rt; rd = v.rd;
      #4;
      m = model_expect(v);
      e = use_tab ? v : m;
      chk("icache_req_ready", icache_req_ready, e.e_ir);
      chk("dcache_req_ready", dcache_req_ready, e.e_dr);
      chk("icache_resp_valid", icache_resp_valid, e.e_irv);
      chk("dcache_resp_valid", dcache_resp_valid, e.e_drv);
      chk("icache_resp_block_data", icache_resp_block_data, v.rd);
      chk("dcache_resp_block_data", dcache_resp_block_data, v.rd);
      chk("mem_req_valid", mem_req_valid, e.e_mv);
      chk("mem_req_cache_type", mem_req_cache_type, e.e_mct);
      chk("mem_req_type", mem_req_type, e.e_mty);
      chk("mem_req_block_addr", mem_req_block_addr, e.e_ma);
      if (e.e_mct) chk("mem_req_block_data", mem_req_block_data, e.e_md);
      chk("protocol_err", protocol_err, e.e_perr);
      @(posedge clk);
      #1;
      model_commit(v, m);
   endtask

   vec_t tab_a[$], tab_b[$], tab_c[$];

   initial begin
      // icache alone, response, re-fire after the response cycle
      tab_a.push_back(mk(1,'h10, 0,0,0,0, 0,0,0,            1,0,0,0, 0,0,0,'h00,0));
      tab_a.push_back(mk(0,0,    0,0,0,0, 0,0,0,            0,0,0,0, 1,0,0,'h10,0));
      tab_a.push_back(mk(1,'h11, 0,0,0,0, 0,0,0,            0,0,0,0, 0,0,0,'h10,0));
      tab_a.push_back(mk(1,'h11, 0,0,0,0, 1,0,64'hDEADBEEF, 0,0,1,0, 0,0,0,'h10,0));
      tab_a.push_back(mk(1,'h11, 0,0,0,0, 0,0,0,            1,0,0,0, 0,0,0,'h10,0));
      tab_a.push_back(mk(0,0,    0,0,0,0, 0,0,0,            0,0,0,0, 1,0,0,'h11,0));
      tab_a.push_back(mk(0,0,    0,0,0,0, 1,0,64'h1234,     0,0,1,0, 0,0,0,'h11,0));

      // both valid, dcache issuing writes
`ifdef MEM_SCHED_RR_EN
      tab_b.push_back(mk(1,'h50, 1,1,'h60,64'hD0, 0,0,0, 1,0,0,0, 0,0,0,'h00,0));
      tab_b.push_back(mk(1,'h50, 1,1,'h60,64'hD0, 0,0,0, 0,1,0,0, 1,0,0,'h50,0));
      tab_b.push_back(mk(1,'h50, 1,1,'h61,64'hD1, 1,0,7, 0,1,1,0, 1,1,1,'h60,64'hD0));
      tab_b.push_back(mk(1,'h50, 1,1,'h62,64'hD2, 0,0,0, 1,0,0,0, 1,1,1,'h61,64'hD1));
      tab_b.push_back(mk(1,'h50, 1,1,'h62,64'hD2, 0,0,0, 0,1,0,0, 1,0,0,'h50,0));
      tab_b.push_back(mk(0,0,    0,0,0,0,         1,0,9, 0,0,1,0, 1,1,1,'h62,64'hD2));
      tab_b.push_back(mk(0,0,    0,0,0,0,         0,0,0, 0,0,0,0, 0,1,1,'h62,64'hD2));
`else
      tab_b.push_back(mk(1,'h50, 1,1,'h60,64'hD0, 0,0,0, 0,1,0,0, 0,0,0,'h00,0));
      tab_b.push_back(mk(1,'h50, 1,1,'h61,64'hD1, 0,0,0, 0,1,0,0, 1,1,1,'h60,64'hD0));
      tab_b.push_back(mk(1,'h50, 1,1,'h62,64'hD2, 0,0,0, 0,1,0,0, 1,1,1,'h61,64'hD1));
      tab_b.push_back(mk(1,'h50, 1,1,'h63,64'hD3, 0,0,0, 1,0,0,0, 1,1,1,'h62,64'hD2));
      tab_b.push_back(mk(1,'h50, 1,1,'h63,64'hD3, 0,0,0, 0,1,0,0, 1,0,0,'h50,0));
      tab_b.push_back(mk(0,0,    0,0,0,0,         1,0,5, 0,0,1,0, 1,1,1,'h63,64'hD3));
      tab_b.push_back(mk(0,0,    0,0,0,0,         0,0,0, 0,0,0,0, 0,1,1,'h63,64'hD3));
`endif

      // dcache read busy window, overlapping response/fire, back-to-back writes
      tab_c.push_back(mk(0,0,    1,0,'h20,0, 0,0,0,          0,1,0,0, 0,0,0,'h00,0));
      tab_c.push_back(mk(0,0,    1,0,'h20,0, 0,0,0,          0,0,0,0, 1,1,0,'h20,0));
      tab_c.push_back(mk(0,0,    1,0,'h20,0, 0,0,0,          0,0,0,0, 0,1,0,'h20,0));
      tab_c.push_back(mk(0,0,    1,0,'h20,0, 1,1,64'hCAFE,   0,0,0,1, 0,1,0,'h20,0));
      tab_c.push_back(mk(0,0,    1,0,'h21,0, 0,0,0,          0,1,0,0, 0,1,0,'h20,0));
      tab_c.push_back(mk(0,0,    0,0,0,0,    0,0,0,          0,0,0,0, 1,1,0,'h21,0));
      tab_c.push_back(mk(1,'h30, 0,0,0,0,    1,1,64'hBEEF,   1,0,0,1, 0,1,0,'h21,0));
      tab_c.push_back(mk(0,0,    0,0,0,0,    0,0,0,          0,0,0,0, 1,0,0,'h30,0));
      tab_c.push_back(mk(0,0,    0,0,0,0,    1,0,64'h77,     0,0,1,0, 0,0,0,'h30,0));
      tab_c.push_back(mk(0,0,    1,1,'h40,64'h1111, 0,0,0,   0,1,0,0, 0,0,0,'h30,0));
      tab_c.push_back(mk(0,0,    1,1,'h41,64'h2222, 0,0,0,   0,1,0,0, 1,1,1,'h40,64'h1111));
      tab_c.push_back(mk(0,0,    0,0,0,0,    0,0,0,          0,0,0,0, 1,1,1,'h41,64'h2222));
      tab_c.push_back(mk(0,0,    0,0,0,0,    0,0,0,          0,0,0,0, 0,1,1,'h41,64'h2222));

      do_reset();
      foreach (tab_a[i]) step(tab_a[i], 1);
      do_reset();
      foreach (tab_b[i]) step(tab_b[i], 1);
      do_reset();
      foreach (tab_c[i]) step(tab_c[i], 1);

      // reset while an icache read is outstanding, then a stale tag-0 response
      do_reset();
      iv = 1; ia = 'h70;
      #4;
      chk("stale icache_req_ready", icache_req_ready, 1);
      @(posedge clk);
      #1;
      iv = 0;
      #1;
      chk("stale mem_req_valid issued", mem_req_valid, 1);
      rst_aH = 1;
      #1;
      chk("async reset mem_req_valid", mem_req_valid, 0);
      @(posedge clk);
      #1;
      rst_aH = 0;
      rv = 1; rt = 0; rd = 64'hABC;
      #4;
      chk("stale icache_resp_valid", icache_resp_valid, 0);
      @(posedge clk);
      #1;
      rv = 0;
      for (int k = 0; k < 3; k++) begin
         #4;
         chk("sticky protocol_err", protocol_err, 1);
         @(posedge clk);
         #1;
      end
      do_reset();

      // randomized traffic against the model
      for (int n = 0; n < 600; n++) begin
         vec_t v;
         int   r;
         if (n == 300) do_reset();
         v = mk(0,0,0,0,0,0,0,0,0, 0,0,0,0, 0,0,0,0,0);
         v.iv = 1'($urandom_range(0, 1));
         v.ia = AW'($urandom);
         v.dv = 1'($urandom_range(0, 1));
         v.dt = 1'($urandom_range(0, 1));
         v.da = AW'($urandom);
         v.dd = {$urandom, $urandom};
         v.rd = {$urandom, $urandom};
         r = $urandom_range(0, 99);
         if (r < 45 && (m_busy[0] || m_busy[1])) begin
            v.rv = 1;
            if (m_busy[0] && m_busy[1]) v.rt = 1'($urandom_range(0, 1));
            else v.rt = m_busy[1];
         end else if (r >= 98) begin
            v.rv = 1;
            v.rt = 1'($urandom_range(0, 1));
         end
         step(v, 0);
      end

      drive_idle();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
